jamma_joy_mux: RTL and testbench

Time-multiplexed JAMMA control-panel front end for the arcade ports. The block drives the external player-select line, waits for the shared 8-bit active-low joystick bus to settle, captures player A and player B banks alternately, and debounces each bit. The clean `joy_a`, `joy_b` and `coin_out` words feed the arcade core's joystick, player-start and coin inputs.

---
 rtl/jamma_pkg.sv | 17 +
 rtl/jamma_debounce.sv | 49 ++++
 rtl/jamma_joy_mux.sv | 118 +++++++++++
 tb/tb_jamma_joy_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jamma_pkg.sv
// Shared types and widths for the JAMMA control-panel front end.
package jamma_pkg;

    localparam int JAMMA_W     = 8;
    localparam int JAMMA_DIR_W = 6;
    localparam int COIN_W      = 2;

    localparam logic [JAMMA_W-1:0] JAMMA_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        A_SETTLE = 2'd0,
        A_SAMPLE = 2'd1,
        B_SETTLE = 2'd2,
        B_SAMPLE = 2'd3
    } jamma_state_t;

endpackage

// File: rtl/jamma_debounce.sv
// Single-bit debouncer: the output follows the sample only after
// DEBOUNCE_SAMPLES consecutive sample events that disagree with it.
module jamma_debounce #(
    parameter int DEBOUNCE_SAMPLES = 32'd16
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic sample_in,
    output logic debounced
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_SAMPLES - 32'd1);

    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic       out_s;

    // Next counter/output; the counter clears at threshold so it can never wrap
    always_comb begin
        cnt_s = cnt_r;
        out_s = debounced;
        if (sample_en) begin
            if (sample_in == debounced) begin
                cnt_s = 8'd0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_s = 8'd0;
                out_s = sample_in;
            end else begin
                cnt_s = cnt_r + 8'd1;
            end
        end else begin
            cnt_s = cnt_r;
            out_s = debounced;
        end
    end

    // Counter and debounced output registers, released level on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= 8'd0;
            debounced <= 1'b1;
        end else begin
            cnt_r     <= cnt_s;
            debounced <= out_s;
        end
    end

endmodule

// File: rtl/jamma_joy_mux.sv
// Time-multiplexed JAMMA panel scanner: alternates the player-select line,
// captures each bank on the last clock of its phase and debounces every bit.
module jamma_joy_mux
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 32'd4,
    parameter int DEBOUNCE_SAMPLES = 32'd16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [JAMMA_W-1:0]     joy_in,
    input  logic [JAMMA_DIR_W-1:0] joy_mask_a,
    input  logic [COIN_W-1:0]      coin_in,
    output logic                   joy_select,
    output logic [JAMMA_W-1:0]     joy_a,
    output logic [JAMMA_W-1:0]     joy_b,
    output logic [COIN_W-1:0]      coin_out,
    output logic                   frame_strobe
);

    // Last phase-counter value that still belongs to the settle window
    localparam logic [7:0] PH_LAST_SETTLE = 8'(SETTLE_CYCLES - 32'd2);

    jamma_state_t       state_r;
    jamma_state_t       state_s;
    logic [7:0]         ph_cnt_r;
    logic [7:0]         ph_cnt_s;
    logic               select_s;
    logic               sample_a_s;
    logic               sample_b_s;
    logic [JAMMA_W-1:0] bank_a_s;

    // Scan sequencer: fixed A_SETTLE -> A_SAMPLE -> B_SETTLE -> B_SAMPLE loop
    always_comb begin
        state_s  = state_r;
        ph_cnt_s = ph_cnt_r + 8'd1;
        select_s = joy_select;
        case (state_r)
            A_SETTLE: begin
                if (ph_cnt_r >= PH_LAST_SETTLE) begin
                    state_s = A_SAMPLE;
                end else begin
                    state_s = A_SETTLE;
                end
            end
            A_SAMPLE: begin
                state_s  = B_SETTLE;
                ph_cnt_s = 8'd0;
                select_s = 1'b1;
            end
            B_SETTLE: begin
                if (ph_cnt_r >= PH_LAST_SETTLE) begin
                    state_s = B_SAMPLE;
                end else begin
                    state_s = B_SETTLE;
                end
            end
            B_SAMPLE: begin
                state_s  = A_SETTLE;
                ph_cnt_s = 8'd0;
                select_s = 1'b0;
            end
            default: begin
                state_s  = A_SETTLE;
                ph_cnt_s = 8'd0;
                select_s = 1'b0;
            end
        endcase
    end

    // Sequencer registers; select and strobe are registered straight from the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= A_SETTLE;
            ph_cnt_r     <= 8'd0;
            joy_select   <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            state_r      <= state_s;
            ph_cnt_r     <= ph_cnt_s;
            joy_select   <= select_s;
            frame_strobe <= (state_r == B_SAMPLE);
        end
    end

    assign sample_a_s = (state_r == A_SAMPLE);
    assign sample_b_s = (state_r == B_SAMPLE);
    // The local DB9 stick pulls bank A directions low alongside the JAMMA bus
    assign bank_a_s   = {joy_in[JAMMA_W-1:JAMMA_DIR_W], joy_in[JAMMA_DIR_W-1:0] & joy_mask_a};

    for (genvar gi = 0; gi < JAMMA_W; gi++) begin : g_bank
        jamma_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_a (
            .clk       (clk),
            .reset     (reset),
            .sample_en (sample_a_s),
            .sample_in (bank_a_s[gi]),
            .debounced (joy_a[gi])
        );
        jamma_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_b (
            .clk       (clk),
            .reset     (reset),
            .sample_en (sample_b_s),
            .sample_in (joy_in[gi]),
            .debounced (joy_b[gi])
        );
    end

    for (genvar gc = 0; gc < COIN_W; gc++) begin : g_coin
        jamma_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_coin (
            .clk       (clk),
            .reset     (reset),
            .sample_en (sample_a_s),
            .sample_in (coin_in[gc]),
            .debounced (coin_out[gc])
        );
    end

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Scoreboard bench for jamma_joy_mux with SETTLE_CYCLES=4, DEBOUNCE_SAMPLES=3.
module tb_jamma_joy_mux;

    localparam int S   = 4;
    localparam int DEB = 3;
    localparam int PER = 2 * S;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] joy_in = 8'hFF;
    logic [5:0] joy_mask_a = 6'h3F;
    logic [1:0] coin_in = 2'b11;
    logic       joy_select;
    logic [7:0] joy_a;
    logic [7:0] joy_b;
    logic [1:0] coin_out;
    logic       frame_strobe;

    jamma_joy_mux #(.SETTLE_CYCLES(S), .DEBOUNCE_SAMPLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .joy_in       (joy_in),
        .joy_mask_a   (joy_mask_a),
        .coin_in      (coin_in),
        .joy_select   (joy_select),
        .joy_a        (joy_a),
        .joy_b        (joy_b),
        .coin_out     (coin_out),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] coin;
        logic       sel;
        logic       strobe;
    } exp_t;

    exp_t       sbq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] ja_val   = 8'hFF;
    logic [7:0] jb_val   = 8'hFF;
    logic [5:0] mask_val = 6'h3F;
    logic [1:0] coin_val = 2'b11;

    // Independent model: output bit flips once the last DEB samples all oppose it
    logic [7:0] hist [3][DEB];
    int         hcnt [3];
    logic [7:0] mo   [3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hcnt[k] = 0;
            mo[k]   = 8'hFF;
            for (int i = 0; i < DEB; i++) hist[k][i] = 8'hFF;
        end
        sbq.delete();
        cyc = 0;
    endtask

    task automatic sample_bank(input int k, input logic [7:0] s);
        logic all_opp;
        for (int i = DEB - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = s;
        if (hcnt[k] < DEB) hcnt[k]++;
        if (hcnt[k] == DEB) begin
            for (int b = 0; b < 8; b++) begin
                all_opp = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (hist[k][i][b] == mo[k][b]) all_opp = 1'b0;
                if (all_opp) mo[k][b] = s[b];
            end
        end
    endtask

    task automatic compare_now(input exp_t e);
        check_val("joy_a", {24'd0, joy_a}, {24'd0, e.a});
        check_val("joy_b", {24'd0, joy_b}, {24'd0, e.b});
        check_val("coin_out", {30'd0, coin_out}, {30'd0, e.coin});
        check_val("joy_select", {31'd0, joy_select}, {31'd0, e.sel});
        check_val("frame_strobe", {31'd0, frame_strobe}, {31'd0, e.strobe});
    endtask

    // One clock: drive inputs for cycle cyc, push expectation for cyc+1, compare it
    task automatic step();
        exp_t e;
        int   ph;
        ph         = cyc % PER;
        joy_in     = (ph >= S) ? jb_val : ja_val;
        joy_mask_a = mask_val;
        coin_in    = coin_val;
        if (ph == S - 1) begin
            sample_bank(0, {ja_val[7:6], ja_val[5:0] & mask_val});
            sample_bank(2, {6'h3F, coin_val});
        end
        if (ph == PER - 1) sample_bank(1, jb_val);
        e.a      = mo[0];
        e.b      = mo[1];
        e.coin   = mo[2][1:0];
        e.sel    = (((cyc + 1) % PER) >= S);
        e.strobe = (((cyc + 1) % PER) == 0);
        sbq.push_back(e);
        @(negedge clk);
        cyc++;
        compare_now(sbq.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        e = '{a: 8'hFF, b: 8'hFF, coin: 2'b11, sel: 1'b0, strobe: 1'b0};
        compare_now(e);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset / free-running scan
        do_reset();
        run(26);
        // Bank separation: FE only while bank A is selected
        do_reset();
        ja_val = 8'hFE; jb_val = 8'hFF;
        run(26);
        // Glitch rejection on bank A bit0 then bank B bit7
        do_reset();
        ja_val = 8'hFE; run(2 * PER);
        ja_val = 8'hFF; run(3 * PER);
        jb_val = 8'h7F; run(2 * PER);
        jb_val = 8'hFF; run(3 * PER);
        // Local mask pulls bank A bit1 low, bank B unaffected
        do_reset();
        mask_val = 6'b111101; run(3 * PER + 2);
        mask_val = 6'h3F;     run(3 * PER + 2);
        // Coins sampled on the bank A edge
        do_reset();
        coin_val = 2'b10; run(3 * PER + 2);
        coin_val = 2'b11; run(3 * PER + 2);
        // Reset asserted mid B_SETTLE with joy_a held at FE
        do_reset();
        ja_val = 8'hFE; run(3 * PER);
        while ((cyc % PER) != S + 1) step();
        #2 reset = 1'b1;
        #1;
        check_val("rst_mid_joy_a", {24'd0, joy_a}, 32'h0000_00FF);
        check_val("rst_mid_select", {31'd0, joy_select}, 32'd0);
        check_val("rst_mid_strobe", {31'd0, frame_strobe}, 32'd0);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        run(4 * PER);
        ja_val = 8'hFF; mask_val = 6'h3F;
        run(3 * PER);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
